// File: rtl/pq_seq_pkg.sv
// Shared types and defaults for the priority-queue request sequencer.
package pq_seq_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ENQ = 2'd1,
    OP_DEQ = 2'd2,
    OP_REP = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_FULL  = 2'd1,
    ST_EMPTY = 2'd2,
    ST_UNSUP = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_SETTLE = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  localparam int DEF_QUEUE_SIZE = 64;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ENQ_WAIT   = DEF_QUEUE_SIZE / 2;
  localparam int DEF_OP_WAIT    = 2;

  // Settle-timer width: wide enough for the longer of the two waits, never zero.
  function automatic int timer_width(input int enq_wait, input int op_wait);
    int longest;
    longest = (enq_wait > op_wait) ? enq_wait : op_wait;
    return (longest < 1) ? 1 : $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/pq_settle_timer.sv
// Loadable down-counter that paces the queue's settle window.
// 'last' is high while the count is at 1 (or idle at 0), i.e. the next edge
// brings the count to zero and the window is over.
module pq_settle_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             last
);

  logic [WIDTH-1:0] count;

  // Load on request, otherwise count down and rest at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count <= WIDTH'(1));

endmodule

// File: rtl/pq_request_sequencer.sv
// Valid/ready front-end for register_array_cycled: turns one request at a
// time into single-cycle queue strobes, waits out the queue's settle time,
// then returns popped data and a status code.
// Optional build macro PQ_SEQ_STATS_EN adds three 32-bit wrapping counters
// (strobed enqueues, strobed dequeues/replaces, rejected requests).
module pq_request_sequencer
  import pq_seq_pkg::*;
#(
  parameter int   QUEUE_SIZE = DEF_QUEUE_SIZE,
  parameter int   DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic ENQ_ENA    = 1'b1,
  parameter int   ENQ_WAIT   = QUEUE_SIZE / 2,
  parameter int   OP_WAIT    = DEF_OP_WAIT
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [1:0]            i_req_op,
  input  logic [DATA_WIDTH-1:0] i_req_data,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic [1:0]            o_rsp_status,
  output logic                  o_pq_wrt,
  output logic                  o_pq_read,
  output logic [DATA_WIDTH-1:0] o_pq_data,
  input  logic                  i_pq_full,
  input  logic                  i_pq_empty,
  input  logic [DATA_WIDTH-1:0] i_pq_data
`ifdef PQ_SEQ_STATS_EN
  ,
  output logic [31:0]           o_stat_enq,
  output logic [31:0]           o_stat_deq,
  output logic [31:0]           o_stat_rej
`endif
);

  localparam int TW = timer_width(ENQ_WAIT, OP_WAIT);

  state_e                state;
  state_e                state_next;
  op_e                   op_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  status_e               status_q;

  logic                  accept;
  logic                  timer_load;
  logic [TW-1:0]         timer_value;
  logic                  timer_last;
  status_e               issue_status;
  logic                  capture_top;

  assign accept       = o_req_ready & i_req_valid;
  assign o_pq_data    = data_q;
  assign o_rsp_data   = rsp_data_q;
  assign o_rsp_status = status_q;

  pq_settle_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk       (i_CLK),
    .rst       (i_RST),
    .load      (timer_load),
    .load_value(timer_value),
    .last      (timer_last)
  );

  // FSM state register.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    // NOTE: state elements use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (i_RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode, issue decision and handshake/strobe outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next   = state;
    o_req_ready  = 1'b0;
    o_rsp_valid  = 1'b0;
    o_pq_wrt     = 1'b0;
    o_pq_read    = 1'b0;
    timer_load   = 1'b0;
    timer_value  = '0;
    issue_status = ST_OK;
    capture_top  = 1'b0;

    unique case (state)
      S_IDLE: begin
        // Held low while reset is asserted so every output reads 0 in reset.
        o_req_ready = !i_RST;
        if (i_req_valid) state_next = S_ISSUE;
      end

      S_ISSUE: begin
        state_next = S_RESP;
        unique case (op_q)
          OP_ENQ: begin
            if (!ENQ_ENA) begin
              issue_status = ST_UNSUP;
            end else if (i_pq_full) begin
              issue_status = ST_FULL;
            end else begin
              o_pq_wrt    = 1'b1;
              timer_load  = 1'b1;
              timer_value = TW'(ENQ_WAIT);
              state_next  = (ENQ_WAIT == 0) ? S_RESP : S_SETTLE;
            end
          end
          OP_DEQ: begin
            if (i_pq_empty) begin
              issue_status = ST_EMPTY;
            end else begin
              o_pq_read   = 1'b1;
              capture_top = 1'b1;
              timer_load  = 1'b1;
              timer_value = TW'(OP_WAIT);
              state_next  = (OP_WAIT == 0) ? S_RESP : S_SETTLE;
            end
          end
          OP_REP: begin
            // An empty queue treats the pair as a plain push; nothing to return.
            o_pq_wrt    = 1'b1;
            o_pq_read   = 1'b1;
            capture_top = !i_pq_empty;
            timer_load  = 1'b1;
            timer_value = TW'(OP_WAIT);
            state_next  = (OP_WAIT == 0) ? S_RESP : S_SETTLE;
          end
          OP_NOP: begin
            issue_status = ST_OK;
          end
        endcase
      end

      S_SETTLE: begin
        if (timer_last) state_next = S_RESP;
      end

      S_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_next = S_IDLE;
      end
    endcase
  end

  // Request capture on accept; response data/status resolved in ISSUE.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      op_q       <= OP_NOP;
      data_q     <= '0;
      rsp_data_q <= '0;
      status_q   <= ST_OK;
    end else if (accept) begin
      op_q   <= op_e'(i_req_op);
      data_q <= i_req_data;
    end else if (state == S_ISSUE) begin
      status_q   <= issue_status;
      rsp_data_q <= capture_top ? i_pq_data : '0;
    end
  end

`ifdef PQ_SEQ_STATS_EN
  // Activity counters, bumped once per resolved ISSUE cycle.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      o_stat_enq <= '0;
      o_stat_deq <= '0;
      o_stat_rej <= '0;
    end else if (state == S_ISSUE) begin
      if (o_pq_wrt && !o_pq_read) o_stat_enq <= o_stat_enq + 32'd1;
      if (o_pq_read)              o_stat_deq <= o_stat_deq + 32'd1;
      if (issue_status != ST_OK)  o_stat_rej <= o_stat_rej + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pq_request_sequencer.sv
// Self-checking bench for pq_request_sequencer. A behavioural priority queue
// stands in for register_array_cycled; expected responses come from a table
// of hand-derived vectors and from an abstract reference model (unsorted
// queue, max found by search).
module tb_pq_request_sequencer;

  localparam int QUEUE_SIZE = 64;
  localparam int DW         = 16;
  localparam int ENQ_WAIT   = QUEUE_SIZE / 2;
  localparam int OP_WAIT    = 2;
  localparam int LAT_ENQ    = 2 + ENQ_WAIT;
  localparam int LAT_OP     = 2 + OP_WAIT;
  localparam int LAT_REJ    = 2;

  localparam logic [1:0] NOP = 2'd0, ENQ = 2'd1, DEQ = 2'd2, REP = 2'd3;
  localparam logic [1:0] OK  = 2'd0, FULL = 2'd1, EMPTY = 2'd2;

  logic          i_CLK = 1'b0;
  logic          i_RST;
  logic          i_req_valid;
  logic          o_req_ready;
  logic [1:0]    i_req_op;
  logic [DW-1:0] i_req_data;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [DW-1:0] o_rsp_data;
  logic [1:0]    o_rsp_status;
  logic          o_pq_wrt;
  logic          o_pq_read;
  logic [DW-1:0] o_pq_data;
  logic          pq_full;
  logic          pq_empty;
  logic [DW-1:0] pq_top;
`ifdef PQ_SEQ_STATS_EN
  logic [31:0]   o_stat_enq, o_stat_deq, o_stat_rej;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pq_request_sequencer dut (
    .i_CLK       (i_CLK),
    .i_RST       (i_RST),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_op    (i_req_op),
    .i_req_data  (i_req_data),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_status(o_rsp_status),
    .o_pq_wrt    (o_pq_wrt),
    .o_pq_read   (o_pq_read),
    .o_pq_data   (o_pq_data),
    .i_pq_full   (pq_full),
    .i_pq_empty  (pq_empty),
    .i_pq_data   (pq_top)
`ifdef PQ_SEQ_STATS_EN
    ,
    .o_stat_enq  (o_stat_enq),
    .o_stat_deq  (o_stat_deq),
    .o_stat_rej  (o_stat_rej)
`endif
  );

  always #5 i_CLK = ~i_CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int max_idx(input int q[$]);
    int best = 0;
    for (int i = 1; i < q.size(); i++) if (q[i] > q[best]) best = i;
    return best;
  endfunction

  // ---------------- behavioural queue environment ----------------
  int            env_q[$];
  logic          pend_w = 1'b0, pend_r = 1'b0;
  logic [DW-1:0] pend_d = '0;

  function automatic void env_refresh();
    pq_full  = (env_q.size() >= QUEUE_SIZE);
    pq_empty = (env_q.size() == 0);
    pq_top   = pq_empty ? '0 : DW'(env_q[max_idx(env_q)]);
  endfunction

  // Strobes seen in one cycle take effect a cycle later, inside the settle window.
  always @(negedge i_CLK) begin
    if (i_RST) begin
      env_q.delete();
      pend_w = 1'b0;
      pend_r = 1'b0;
    end else begin
      if (pend_w && pend_r) begin
        if (env_q.size() == 0) env_q.push_back(int'(pend_d));
        else env_q[max_idx(env_q)] = int'(pend_d);
      end else if (pend_w) begin
        if (env_q.size() < QUEUE_SIZE) env_q.push_back(int'(pend_d));
      end else if (pend_r) begin
        if (env_q.size() > 0) env_q.delete(max_idx(env_q));
      end
      pend_w = o_pq_wrt;
      pend_r = o_pq_read;
      pend_d = o_pq_data;
    end
    env_refresh();
  end

  // ---------------- reference model ----------------
  int ref_q[$];

  task automatic ref_step(input logic [1:0] op, input logic [DW-1:0] d,
                          output logic [1:0] st, output logic [DW-1:0] rd,
                          output int lat, output int nw, output int nr);
    int i;
    st = OK; rd = '0; lat = LAT_REJ; nw = 0; nr = 0;
    case (op)
      ENQ: begin
        if (ref_q.size() == QUEUE_SIZE) st = FULL;
        else begin ref_q.push_back(int'(d)); lat = LAT_ENQ; nw = 1; end
      end
      DEQ: begin
        if (ref_q.size() == 0) st = EMPTY;
        else begin
          i = max_idx(ref_q); rd = DW'(ref_q[i]); ref_q.delete(i);
          lat = LAT_OP; nr = 1;
        end
      end
      REP: begin
        nw = 1; nr = 1; lat = LAT_OP;
        if (ref_q.size() == 0) ref_q.push_back(int'(d));
        else begin i = max_idx(ref_q); rd = DW'(ref_q[i]); ref_q[i] = int'(d); end
      end
      default: ;
    endcase
  endtask

  // ---------------- request driver (call and return at a negedge) ----------------
  task automatic do_req(input string tag, input logic [1:0] op, input logic [DW-1:0] d,
                        input int hold, output logic [1:0] st, output logic [DW-1:0] rd,
                        output int lat, output int nw, output int nr);
    int n;
    nw = 0; nr = 0; lat = -1; st = 2'd0; rd = '0;
    i_req_valid = 1'b1; i_req_op = op; i_req_data = d;
    n = 0;
    while (!o_req_ready && n < 100) begin @(negedge i_CLK); n++; end
    if (!o_req_ready) begin
      check({tag, "_accept_timeout"}, 0, 1);
      i_req_valid = 1'b0;
      return;
    end
    @(negedge i_CLK);
    i_req_valid = 1'b0; i_req_op = 2'd0; i_req_data = '0;
    for (n = 1; n <= 200; n++) begin
      if (o_pq_wrt)  nw++;
      if (o_pq_read) nr++;
      if (o_rsp_valid) begin lat = n; break; end
      @(negedge i_CLK);
    end
    if (lat < 0) begin
      check({tag, "_rsp_timeout"}, 0, 1);
      return;
    end
    st = o_rsp_status; rd = o_rsp_data;
    for (int k = 0; k < hold; k++) begin
      @(negedge i_CLK);
      check({tag, "_hold_valid"},  o_rsp_valid, 1);
      check({tag, "_hold_data"},   o_rsp_data, rd);
      check({tag, "_hold_status"}, o_rsp_status, st);
      check({tag, "_hold_ready"},  o_req_ready, 0);
    end
    i_rsp_ready = 1'b1;
    @(negedge i_CLK);
    i_rsp_ready = 1'b0;
    check({tag, "_rsp_release"}, {o_rsp_valid, o_req_ready}, 2'b01);
  endtask

  task automatic exec(input string tag, input logic [1:0] op, input logic [DW-1:0] d, input int hold,
                      input logic [1:0] e_st, input logic [DW-1:0] e_rd,
                      input int e_lat, input int e_nw, input int e_nr);
    logic [1:0] st; logic [DW-1:0] rd; int lat, nw, nr;
    do_req(tag, op, d, hold, st, rd, lat, nw, nr);
    check({tag, "_status"},  st,  e_st);
    check({tag, "_data"},    rd,  e_rd);
    check({tag, "_latency"}, lat, e_lat);
    check({tag, "_wrt"},     nw,  e_nw);
    check({tag, "_read"},    nr,  e_nr);
  endtask

  task automatic exec_ref(input string tag, input logic [1:0] op, input logic [DW-1:0] d, input int hold);
    logic [1:0] st; logic [DW-1:0] rd; int lat, nw, nr;
    ref_step(op, d, st, rd, lat, nw, nr);
    exec(tag, op, d, hold, st, rd, lat, nw, nr);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, o_req_ready, 0);
    check({tag, "_rsp_valid"}, o_rsp_valid, 0);
    check({tag, "_pq_wrt"},    o_pq_wrt, 0);
    check({tag, "_pq_read"},   o_pq_read, 0);
    check({tag, "_rsp_data"},  o_rsp_data, 0);
    check({tag, "_status"},    o_rsp_status, 0);
    check({tag, "_pq_data"},   o_pq_data, 0);
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] data;
    logic [1:0]    st;
    logic [DW-1:0] rd;
    int            lat;
    int            nw;
    int            nr;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] op, input logic [DW-1:0] data, input logic [1:0] st,
                              input logic [DW-1:0] rd, input int lat, input int nw, input int nr);
    vec_t v;
    v.op = op; v.data = data; v.st = st; v.rd = rd; v.lat = lat; v.nw = nw; v.nr = nr;
    return v;
  endfunction

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no completion, expected summary before time limit");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    logic [1:0] st; logic [DW-1:0] rd; int lat, nw, nr;
    int cnt;

    vecs.push_back(mk(DEQ, 16'd0,   EMPTY, 16'd0,   LAT_REJ, 0, 0));
    vecs.push_back(mk(ENQ, 16'd5,   OK,    16'd0,   LAT_ENQ, 1, 0));
    vecs.push_back(mk(ENQ, 16'd900, OK,    16'd0,   LAT_ENQ, 1, 0));
    vecs.push_back(mk(ENQ, 16'd17,  OK,    16'd0,   LAT_ENQ, 1, 0));
    vecs.push_back(mk(DEQ, 16'd0,   OK,    16'd900, LAT_OP,  0, 1));
    vecs.push_back(mk(DEQ, 16'd0,   OK,    16'd17,  LAT_OP,  0, 1));
    vecs.push_back(mk(DEQ, 16'd0,   OK,    16'd5,   LAT_OP,  0, 1));
    vecs.push_back(mk(NOP, 16'd123, OK,    16'd0,   LAT_REJ, 0, 0));
    vecs.push_back(mk(REP, 16'd7,   OK,    16'd0,   LAT_OP,  1, 1));
    vecs.push_back(mk(ENQ, 16'd900, OK,    16'd0,   LAT_ENQ, 1, 0));
    vecs.push_back(mk(REP, 16'd12,  OK,    16'd900, LAT_OP,  1, 1));
    vecs.push_back(mk(DEQ, 16'd0,   OK,    16'd12,  LAT_OP,  0, 1));
    vecs.push_back(mk(DEQ, 16'd0,   OK,    16'd7,   LAT_OP,  0, 1));
    vecs.push_back(mk(DEQ, 16'd0,   EMPTY, 16'd0,   LAT_REJ, 0, 0));

    i_RST = 1'b1; i_req_valid = 1'b0; i_req_op = 2'd0; i_req_data = '0; i_rsp_ready = 1'b0;
    env_refresh();
    #3;
    check_all_zero("reset");
    repeat (2) @(negedge i_CLK);
    i_RST = 1'b0;
    @(negedge i_CLK);
    check("ready_after_reset", o_req_ready, 1);

    // Directed vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      ref_step(vecs[i].op, vecs[i].data, st, rd, lat, nw, nr);
      exec($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, 0,
           vecs[i].st, vecs[i].rd, vecs[i].lat, vecs[i].nw, vecs[i].nr);
    end

    // Response backpressure: data/status stable, no new accept while held.
    exec_ref("bp_enq", ENQ, 16'd42, 0);
    exec_ref("bp_deq", DEQ, 16'd0, 10);

    // Fill to capacity, reject one more ENQ, then drain in priority order.
    for (int i = 0; i < QUEUE_SIZE; i++) exec_ref("fill", ENQ, DW'(i * 37 + 1), 0);
    ref_step(ENQ, 16'd3, st, rd, lat, nw, nr);
    exec("full_enq", ENQ, 16'd3, 0, FULL, 16'd0, LAT_REJ, 0, 0);
    #1;
    check("full_env_size", env_q.size(), QUEUE_SIZE);
    for (int i = 0; i < QUEUE_SIZE; i++) exec_ref("drain", DEQ, 16'd0, 0);
    exec_ref("drain_empty", DEQ, 16'd0, 0);

    // Reset while the enqueue strobe is high: strobe drops at once.
    @(negedge i_CLK);
    i_req_valid = 1'b1; i_req_op = ENQ; i_req_data = 16'd55;
    @(negedge i_CLK);
    i_req_valid = 1'b0;
    check("issue_wrt_before_rst", o_pq_wrt, 1);
    #1 i_RST = 1'b1;
    #1 check("issue_wrt_after_rst", o_pq_wrt, 0);
    check("issue_ready_in_rst", o_req_ready, 0);
    repeat (2) @(negedge i_CLK);
    i_RST = 1'b0;
    ref_q.delete();

    // Reset in the middle of an ENQ settle window: no response afterwards.
    @(negedge i_CLK);
    i_req_valid = 1'b1; i_req_op = ENQ; i_req_data = 16'd77;
    @(negedge i_CLK);
    i_req_valid = 1'b0;
    repeat (5) @(negedge i_CLK);
    check("settle_no_rsp", o_rsp_valid, 0);
    #2 i_RST = 1'b1;
    #1 check_all_zero("settle_rst");
    repeat (2) @(negedge i_CLK);
    i_RST = 1'b0;
    ref_q.delete();
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge i_CLK);
      if (o_rsp_valid) cnt++;
    end
    check("post_rst_rsp_count", cnt, 0);
    check("post_rst_ready", o_req_ready, 1);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 150; i++) begin
      int r;
      logic [1:0] op;
      r = $urandom_range(0, 9);
      op = (r < 5) ? ENQ : (r < 8) ? DEQ : (r == 8) ? REP : NOP;
      exec_ref($sformatf("rnd%0d", i), op, DW'($urandom), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
